// File: rtl/maple_link_ctrl_if.sv
// maple_link_ctrl_if
//   Bundles the Maple link sequencer's bus/handshake signals.
//   master : the sequencer (samples the bus lines and FIFO/tx/rx status, drives the control outputs)
//   slave  : the environment (FIFO bridge, transmitter, receiver)
//   Signals:
//     sdcka_in, sdckb_in  bus lines as seen by the receiver
//     frame_ready         FIFO holds a complete outbound frame
//     tx_busy, rx_busy    transmitter / receiver busy
//     tx_enable           start request to transmitter
//     rx_listen           reply expected
//     xfer_done           1-cycle pulse, received frame completed
//     unsolicited         valid with xfer_done, frame not preceded by our TX
//     rx_timeout          1-cycle pulse, no reply in time
//     tx_fail             1-cycle pulse, transmitter never started
//     state               current sequencer state (debug)
interface maple_link_ctrl_if;
  logic       sdcka_in;
  logic       sdckb_in;
  logic       frame_ready;
  logic       tx_busy;
  logic       rx_busy;
  logic       tx_enable;
  logic       rx_listen;
  logic       xfer_done;
  logic       unsolicited;
  logic       rx_timeout;
  logic       tx_fail;
  logic [2:0] state;

  modport master (
    input  sdcka_in, sdckb_in, frame_ready, tx_busy, rx_busy,
    output tx_enable, rx_listen, xfer_done, unsolicited, rx_timeout, tx_fail, state
  );

  modport slave (
    output sdcka_in, sdckb_in, frame_ready, tx_busy, rx_busy,
    input  tx_enable, rx_listen, xfer_done, unsolicited, rx_timeout, tx_fail, state
  );
endinterface

// File: rtl/maple_link_ctrl.sv
// maple_link_ctrl
//   Half-duplex Maple bus link sequencer. Decides when the transmitter may drive the bus
//   (after a run of bus-idle cycles) and when a reply is expected (after a turnaround gap),
//   with a start limit on the transmitter and a reply timeout.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     link   maple_link_ctrl_if.master (bus lines, FIFO/tx/rx status in; control outputs out)
//   All outputs are registered; the pulse outputs last exactly one cycle.
module maple_link_ctrl #(
  parameter int IDLE_CYCLES  = 16,
  parameter int TURN_CYCLES  = 8,
  parameter int RESP_TIMEOUT = 50000,
  parameter int START_LIMIT  = 8,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               reset,
  maple_link_ctrl_if.master link
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BUS_IDLE  = 3'd1,
    TX_START  = 3'd2,
    TX_ACTIVE = 3'd3,
    TURN      = 3'd4,
    RX_WAIT   = 3'd5,
    RX_ACTIVE = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LIMIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             unsol_q, unsol_d;
  logic             tx_fail_d, rx_timeout_d;
  logic             lines_high;

  assign lines_high = link.sdcka_in & link.sdckb_in;
  // Saturate rather than wrap so a stuck state can never alias a terminal count.
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    unsol_d      = unsol_q;
    tx_fail_d    = 1'b0;
    rx_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        // An incoming frame outranks our own pending request.
        if (link.rx_busy) begin
          state_d = RX_ACTIVE;
          unsol_d = 1'b1;
        end else if (link.frame_ready) begin
          state_d = BUS_IDLE;
        end
      end
      BUS_IDLE: begin
        // Someone else grabbed the bus; our frame stays queued and is retried later.
        if (link.rx_busy) begin
          state_d = RX_ACTIVE;
          unsol_d = 1'b1;
        end else if (!link.frame_ready) begin
          state_d = IDLE;
        end else if (!lines_high) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = TX_START;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TX_START: begin
        if (link.tx_busy) begin
          state_d = TX_ACTIVE;
        end else if (cnt_q == START_LAST) begin
          state_d   = IDLE;
          tx_fail_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TX_ACTIVE: begin
        if (!link.tx_busy) state_d = TURN;
      end
      TURN: begin
        // Bus echo of our own transmission can look like activity; ignore it here.
        if (cnt_q == TURN_LAST) state_d = RX_WAIT;
        else                    cnt_d   = cnt_inc;
      end
      RX_WAIT: begin
        if (link.rx_busy) begin
          state_d = RX_ACTIVE;
          unsol_d = 1'b0;
        end else if (cnt_q == RESP_LAST) begin
          state_d      = IDLE;
          rx_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RX_ACTIVE: begin
        if (!link.rx_busy) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are computed from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      unsol_q          <= 1'b0;
      link.tx_enable   <= 1'b0;
      link.rx_listen   <= 1'b0;
      link.xfer_done   <= 1'b0;
      link.unsolicited <= 1'b0;
      link.rx_timeout  <= 1'b0;
      link.tx_fail     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      unsol_q          <= unsol_d;
      link.tx_enable   <= (state_d == TX_START);
      link.rx_listen   <= (state_d == RX_WAIT);
      link.xfer_done   <= (state_d == DONE);
      link.unsolicited <= (state_d == DONE) && unsol_d;
      link.rx_timeout  <= rx_timeout_d;
      link.tx_fail     <= tx_fail_d;
    end
  end

  assign link.state = state_q;

endmodule

// File: tb/tb_maple_link_ctrl.sv
// tb_maple_link_ctrl
//   Directed bench for maple_link_ctrl with RESP_TIMEOUT shortened to 100.
//   Inputs change 1 ns after each rising edge and outputs are sampled there too.
module tb_maple_link_ctrl;

  logic clk;
  logic reset;
  int   vecCount;
  int   errCount;

  maple_link_ctrl_if link ();

  maple_link_ctrl #(
    .IDLE_CYCLES (16),
    .TURN_CYCLES (8),
    .RESP_TIMEOUT(100),
    .START_LIMIT (8),
    .CNT_W       (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .link (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fr, input logic txb, input logic rxb,
                               input logic la, input logic lb);
    link.frame_ready = fr;
    link.tx_busy     = txb;
    link.rx_busy     = rxb;
    link.sdcka_in    = la;
    link.sdckb_in    = lb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {link.tx_enable, link.rx_listen, link.xfer_done,
            link.unsolicited, link.rx_timeout, link.tx_fail};
  endfunction

  // IDLE -> BUS_IDLE (1 edge) -> 16 idle cycles -> TX_START -> TX_ACTIVE -> TURN (8) -> RX_WAIT
  task automatic goToRxWait();
    applyStimulus(1, 0, 0, 1, 1);
    step(17);
    checkOutput("g_txstart", link.state, 2);
    applyStimulus(0, 1, 0, 1, 1);
    step(1);
    applyStimulus(0, 0, 0, 1, 1);
    step(1);
    checkOutput("g_turn", link.state, 4);
    step(8);
    checkOutput("g_rxwait", link.state, 5);
  endtask

  initial begin
    vecCount = 0;
    errCount = 0;
    reset    = 1'b1;
    applyStimulus(0, 0, 0, 1, 1);
    step(2);
    checkOutput("rst_state", link.state, 0);
    checkOutput("rst_outs", outs(), 0);
    reset = 1'b0;
    step(1);

    // Request path
    applyStimulus(1, 0, 0, 1, 1);
    step(1);
    checkOutput("t1_busidle", link.state, 1);
    step(15);
    checkOutput("t1_still_busidle", link.state, 1);
    checkOutput("t1_no_txen_early", link.tx_enable, 0);
    step(1);
    checkOutput("t1_txstart", link.state, 2);
    checkOutput("t1_txen", link.tx_enable, 1);
    applyStimulus(0, 0, 0, 1, 1);
    step(3);
    checkOutput("t1_txen_held", link.tx_enable, 1);
    applyStimulus(0, 1, 0, 1, 1);
    step(1);
    checkOutput("t1_txactive", link.state, 3);
    checkOutput("t1_txen_low", link.tx_enable, 0);
    applyStimulus(0, 1, 1, 1, 1);
    step(2);
    checkOutput("t1_rx_masked", link.state, 3);
    applyStimulus(0, 0, 0, 1, 1);
    step(1);
    checkOutput("t1_turn", link.state, 4);
    applyStimulus(0, 0, 1, 1, 1);
    step(3);
    applyStimulus(0, 0, 0, 1, 1);
    step(4);
    checkOutput("t1_turn_hold", link.state, 4);
    checkOutput("t1_no_listen", link.rx_listen, 0);
    step(1);
    checkOutput("t1_rxwait", link.state, 5);
    checkOutput("t1_listen", link.rx_listen, 1);

    // Reply
    step(39);
    checkOutput("t2_wait", link.state, 5);
    applyStimulus(0, 0, 1, 1, 1);
    step(1);
    checkOutput("t2_rxactive", link.state, 6);
    checkOutput("t2_listen_low", link.rx_listen, 0);
    step(3);
    checkOutput("t2_rxactive_hold", link.state, 6);
    applyStimulus(0, 0, 0, 1, 1);
    step(1);
    checkOutput("t2_done", link.state, 7);
    checkOutput("t2_outs", outs(), 6'b001000);
    step(1);
    checkOutput("t2_idle", link.state, 0);
    checkOutput("t2_outs_clr", outs(), 0);

    // Timeout
    goToRxWait();
    step(99);
    checkOutput("t3_before_to", link.state, 5);
    checkOutput("t3_no_to_yet", link.rx_timeout, 0);
    step(1);
    checkOutput("t3_to_idle", link.state, 0);
    checkOutput("t3_to_outs", outs(), 6'b000010);
    step(1);
    checkOutput("t3_to_pulse_end", link.rx_timeout, 0);

    // Reply on the timeout cycle wins
    goToRxWait();
    step(99);
    applyStimulus(0, 0, 1, 1, 1);
    step(1);
    checkOutput("t3v_rxactive", link.state, 6);
    checkOutput("t3v_no_to", link.rx_timeout, 0);
    applyStimulus(0, 0, 0, 1, 1);
    step(1);
    checkOutput("t3v_done", outs(), 6'b001000);
    step(1);

    // Busy bus restarts the idle count
    applyStimulus(1, 0, 0, 1, 1);
    step(1);
    step(10);
    applyStimulus(1, 0, 0, 0, 1);
    step(1);
    applyStimulus(1, 0, 0, 1, 1);
    step(15);
    checkOutput("t4_restart_hold", link.state, 1);
    step(1);
    checkOutput("t4_txstart", link.state, 2);

    // Dead transmitter (frame still pending)
    step(7);
    checkOutput("t5_txstart_hold", link.state, 2);
    checkOutput("t5_no_fail_yet", link.tx_fail, 0);
    step(1);
    checkOutput("t5_idle", link.state, 0);
    checkOutput("t5_fail_outs", outs(), 6'b000001);
    step(1);
    checkOutput("t5_retry", link.state, 1);
    checkOutput("t5_fail_end", link.tx_fail, 0);

    // Unsolicited frame during BUS_IDLE
    applyStimulus(1, 0, 1, 1, 1);
    step(1);
    checkOutput("t4_unsol_rx", link.state, 6);
    applyStimulus(0, 0, 0, 1, 1);
    step(1);
    checkOutput("t4_unsol_done", outs(), 6'b001100);
    step(1);
    checkOutput("t4_unsol_idle", link.state, 0);

    // Reset in TX_ACTIVE
    applyStimulus(1, 0, 0, 1, 1);
    step(17);
    applyStimulus(0, 1, 0, 1, 1);
    step(1);
    checkOutput("t6_txactive", link.state, 3);
    reset = 1'b1;
    step(1);
    checkOutput("t6_rst_tx_state", link.state, 0);
    checkOutput("t6_rst_tx_outs", outs(), 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 1);
    step(1);
    checkOutput("t6_after_rst_outs", outs(), 0);

    // Reset in RX_WAIT
    goToRxWait();
    step(5);
    reset = 1'b1;
    step(1);
    checkOutput("t6_rst_rx_state", link.state, 0);
    checkOutput("t6_rst_rx_outs", outs(), 0);
    reset = 1'b0;
    step(1);

    // rx_busy beats frame_ready in IDLE
    applyStimulus(1, 0, 1, 1, 1);
    step(1);
    checkOutput("t6_prio_rx", link.state, 6);
    checkOutput("t6_prio_outs", outs(), 0);
    applyStimulus(0, 0, 0, 1, 1);
    step(1);
    checkOutput("t6_prio_done", outs(), 6'b001100);
    step(1);
    checkOutput("t6_prio_idle", link.state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
